// File: rtl/renkon_serial_if.sv
// rtl/renkon_serial_if.sv - capture and feature-memory write bus for renkon_serial
interface renkon_serial_if #(
  parameter int DWIDTH  = 16,
  parameter int CORE    = 8,
  parameter int CORELOG = 3,
  parameter int OUTSIZE = 12
);
  logic                     serial_we;
  logic [CORE*DWIDTH-1:0]   in_data;
  logic [OUTSIZE-1:0]       base_addr;
  logic [OUTSIZE-1:0]       stride;
  logic [CORELOG:0]         n_lanes;
  logic                     mem_we;
  logic [OUTSIZE-1:0]       mem_addr;
  logic signed [DWIDTH-1:0] mem_data;

  modport master (
    output serial_we, in_data, base_addr, stride, n_lanes,
    input  mem_we, mem_addr, mem_data
  );

  modport slave (
    input  serial_we, in_data, base_addr, stride, n_lanes,
    output mem_we, mem_addr, mem_data
  );
endinterface

// File: rtl/renkon_serial.sv
// rtl/renkon_serial.sv - captures parallel pool lanes and drains them one write per cycle
module renkon_serial #(
  parameter int DWIDTH  = 16,
  parameter int CORE    = 8,
  parameter int CORELOG = 3,
  parameter int OUTSIZE = 12
) (
  input  logic           clk,
  input  logic           xrst,
  renkon_serial_if.slave bus,
  input  logic           overrun_clr,
  output logic           busy,
  output logic           done,
  output logic           overrun
);
  localparam int CW = CORELOG + 1;

  typedef enum logic {IDLE = 1'b0, DRAIN = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            idx_q, idx_d;
  logic [CW-1:0]            count_q, count_d;
  logic [OUTSIZE-1:0]       stride_q, stride_d;
  logic signed [DWIDTH-1:0] lanes_q [CORE];
  logic signed [DWIDTH-1:0] lanes_d [CORE];
  logic                     mem_we_q, mem_we_d;
  logic [OUTSIZE-1:0]       mem_addr_q, mem_addr_d;
  logic signed [DWIDTH-1:0] mem_data_q, mem_data_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     overrun_q, overrun_d;

  logic          accept;
  logic          last;
  logic          ovr_set;
  logic [CW-1:0] clamped;
  logic [CW-1:0] idx_inc;

  assign accept  = bus.serial_we && (bus.n_lanes != '0);
  assign clamped = (bus.n_lanes > CW'(CORE)) ? CW'(CORE) : bus.n_lanes;
  assign last    = (idx_q == count_q - CW'(1));
  assign idx_inc = idx_q + CW'(1);

  always_ff @(posedge clk) begin
    if (!xrst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      stride_q   <= '0;
      lanes_q    <= '{default: '0};
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      count_q    <= count_d;
      stride_q   <= stride_d;
      lanes_q    <= lanes_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
    end
  end

  // A capture immediately presents write 0, so the registered outputs carry the first write
  // in the cycle after the strobe; mem_addr_q doubles as the address accumulator.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    count_d    = count_q;
    stride_d   = stride_q;
    lanes_d    = lanes_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ovr_set    = 1'b0;

    if ((state_q == IDLE) || last) begin
      if (accept) begin
        state_d    = DRAIN;
        idx_d      = '0;
        count_d    = clamped;
        stride_d   = bus.stride;
        for (int k = 0; k < CORE; k++) begin
          lanes_d[k] = bus.in_data[k*DWIDTH +: DWIDTH];
        end
        mem_we_d   = 1'b1;
        mem_addr_d = bus.base_addr;
        mem_data_d = bus.in_data[DWIDTH-1:0];
        busy_d     = 1'b1;
        done_d     = (clamped == CW'(1));
      end else begin
        state_d = IDLE;
        idx_d   = '0;
      end
    end else begin
      idx_d      = idx_inc;
      mem_we_d   = 1'b1;
      mem_addr_d = mem_addr_q + stride_q;
      mem_data_d = lanes_q[idx_inc[CORELOG-1:0]];
      busy_d     = 1'b1;
      done_d     = (idx_inc == count_q - CW'(1));
      ovr_set    = accept;
    end

    // Set is applied after clear so a coincident set wins.
    overrun_d = overrun_q;
    if (overrun_clr) overrun_d = 1'b0;
    if (ovr_set)     overrun_d = 1'b1;
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_data = mem_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign overrun      = overrun_q;
endmodule

// File: tb/tb_renkon_serial.sv
// tb/tb_renkon_serial.sv - self-checking bench for renkon_serial
module tb_renkon_serial;
  logic clk = 1'b0;
  logic xrst = 1'b0;
  logic overrun_clr = 1'b0;
  logic busy, done, overrun;

  renkon_serial_if bus ();

  renkon_serial dut (
    .clk         (clk),
    .xrst        (xrst),
    .bus         (bus.slave),
    .overrun_clr (overrun_clr),
    .busy        (busy),
    .done        (done),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] data;
    logic        busy;
    logic        done;
  } cyc_t;

  cyc_t              exp_q[$];
  int                n_cmp = 0;
  int                n_err = 0;
  logic [11:0]       prev_addr = '0;
  logic [15:0]       prev_data = '0;
  logic signed [15:0] lane_a [8];
  logic signed [15:0] lane_b [8];

  function automatic cyc_t observe();
    return {bus.mem_we, bus.mem_addr, bus.mem_data, busy, done};
  endfunction

  function automatic cyc_t idle_exp();
    return {1'b0, prev_addr, prev_data, 1'b0, 1'b0};
  endfunction

  // Expected write sequence: lane k goes to base + k*stride modulo 4096, count clamped to 8.
  function automatic void model_capture(int n, logic [11:0] base, logic [11:0] strd,
                                        logic signed [15:0] ln [8]);
    int cnt;
    cnt = (n > 8) ? 8 : n;
    for (int k = 0; k < cnt; k++) begin
      cyc_t e;
      e.we   = 1'b1;
      e.addr = 12'(int'(base) + k * int'(strd));
      e.data = ln[k];
      e.busy = 1'b1;
      e.done = (k == cnt - 1);
      exp_q.push_back(e);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(int n, logic [11:0] base, logic [11:0] strd, logic signed [15:0] ln [8]);
    bus.serial_we = 1'b1;
    bus.n_lanes   = 4'(n);
    bus.base_addr = base;
    bus.stride    = strd;
    for (int k = 0; k < 8; k++) bus.in_data[k*16 +: 16] = ln[k];
  endtask

  task automatic rand_lanes_a();
    for (int k = 0; k < 8; k++) lane_a[k] = 16'($urandom);
  endtask

  task automatic rand_lanes_b();
    for (int k = 0; k < 8; k++) lane_b[k] = 16'($urandom);
  endtask

  task automatic test_reset();
    rand_lanes_a();
    xrst = 1'b0;
    load(8, 12'h123, 12'h011, lane_a);
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if ({observe(), overrun} !== 32'h0) begin
        n_err++;
        $display("FAIL reset_hold got=%h exp=0", {observe(), overrun});
      end
    end
    xrst = 1'b1;
    bus.serial_we = 1'b0;
    tick();
    n_cmp++;
    if ({observe(), overrun} !== 32'h0) begin
      n_err++;
      $display("FAIL reset_release got=%h exp=0", {observe(), overrun});
    end
  endtask

  task automatic test_directed();
    int          ns [4] = '{8, 3, 15, 0};
    logic [11:0] bs [4] = '{12'h010, 12'hFC0, 12'h7A5, 12'h333};
    logic [11:0] ss [4] = '{12'h040, 12'h020, 12'h101, 12'h001};
    for (int c = 0; c < 4; c++) begin
      rand_lanes_a();
      if (c == 0) for (int k = 0; k < 8; k++) lane_a[k] = 16'(k + 1);
      if (c == 1) begin
        lane_a[0] = -16'sd5;
        lane_a[1] = 16'sd7;
        lane_a[2] = -16'sd1;
      end
      exp_q.delete();
      model_capture(ns[c], bs[c], ss[c], lane_a);
      load(ns[c], bs[c], ss[c], lane_a);
      tick();
      bus.serial_we = 1'b0;
      while (exp_q.size() > 0) begin
        cyc_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (observe() !== e) begin
          n_err++;
          $display("FAIL directed%0d_write got=%h exp=%h", c, observe(), e);
        end
        prev_addr = e.addr;
        prev_data = e.data;
        tick();
      end
      n_cmp++;
      if ({observe(), overrun} !== {idle_exp(), 1'b0}) begin
        n_err++;
        $display("FAIL directed%0d_idle got=%h exp=%h", c, {observe(), overrun}, {idle_exp(), 1'b0});
      end
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int          n;
      logic [11:0] b, s;
      n = $urandom_range(0, 15);
      b = 12'($urandom);
      s = 12'($urandom);
      rand_lanes_a();
      exp_q.delete();
      model_capture(n, b, s, lane_a);
      load(n, b, s, lane_a);
      tick();
      bus.serial_we = 1'b0;
      while (exp_q.size() > 0) begin
        cyc_t e;
        e = exp_q.pop_front();
        n_cmp++;
        if (observe() !== e) begin
          n_err++;
          $display("FAIL random%0d_write n=%0d got=%h exp=%h", it, n, observe(), e);
        end
        prev_addr = e.addr;
        prev_data = e.data;
        tick();
      end
      n_cmp++;
      if ({observe(), overrun} !== {idle_exp(), 1'b0}) begin
        n_err++;
        $display("FAIL random%0d_idle got=%h exp=%h", it, {observe(), overrun}, {idle_exp(), 1'b0});
      end
    end
  endtask

  task automatic test_back_to_back();
    rand_lanes_a();
    rand_lanes_b();
    exp_q.delete();
    model_capture(4, 12'h100, 12'h010, lane_a);
    model_capture(4, 12'hFF0, 12'h008, lane_b);
    load(4, 12'h100, 12'h010, lane_a);
    tick();
    bus.serial_we = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (observe() !== e) begin
        n_err++;
        $display("FAIL b2b_write%0d got=%h exp=%h", i, observe(), e);
      end
      prev_addr = e.addr;
      prev_data = e.data;
      if (i == 3) load(4, 12'hFF0, 12'h008, lane_b);
      tick();
      bus.serial_we = 1'b0;
    end
    n_cmp++;
    if ({observe(), overrun} !== {idle_exp(), 1'b0}) begin
      n_err++;
      $display("FAIL b2b_idle got=%h exp=%h", {observe(), overrun}, {idle_exp(), 1'b0});
    end
  endtask

  task automatic test_overrun();
    rand_lanes_a();
    rand_lanes_b();
    exp_q.delete();
    model_capture(8, 12'h200, 12'h031, lane_a);
    load(8, 12'h200, 12'h031, lane_a);
    tick();
    bus.serial_we = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (observe() !== e) begin
        n_err++;
        $display("FAIL ovr_write%0d got=%h exp=%h", i, observe(), e);
      end
      prev_addr = e.addr;
      prev_data = e.data;
      if (i == 1) load(5, 12'h555, 12'h001, lane_b);
      tick();
      bus.serial_we = 1'b0;
    end
    n_cmp++;
    if ({observe(), overrun} !== {idle_exp(), 1'b1}) begin
      n_err++;
      $display("FAIL ovr_sticky got=%h exp=%h", {observe(), overrun}, {idle_exp(), 1'b1});
    end
    tick();
    tick();
    n_cmp++;
    if (overrun !== 1'b1) begin
      n_err++;
      $display("FAIL ovr_hold got=%b exp=1", overrun);
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_err++;
      $display("FAIL ovr_clear got=%b exp=0", overrun);
    end
    // Coincident set and clear must leave the flag set.
    exp_q.delete();
    model_capture(4, 12'h040, 12'h004, lane_a);
    load(4, 12'h040, 12'h004, lane_a);
    tick();
    bus.serial_we = 1'b0;
    for (int i = 0; exp_q.size() > 0; i++) begin
      cyc_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (observe() !== e) begin
        n_err++;
        $display("FAIL ovr2_write%0d got=%h exp=%h", i, observe(), e);
      end
      prev_addr = e.addr;
      prev_data = e.data;
      if (i == 1) begin
        load(3, 12'h777, 12'h002, lane_b);
        overrun_clr = 1'b1;
      end
      tick();
      bus.serial_we = 1'b0;
      overrun_clr = 1'b0;
    end
    n_cmp++;
    if ({observe(), overrun} !== {idle_exp(), 1'b1}) begin
      n_err++;
      $display("FAIL ovr_setclr got=%h exp=%h", {observe(), overrun}, {idle_exp(), 1'b1});
    end
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
  endtask

  task automatic test_reset_mid();
    rand_lanes_a();
    rand_lanes_b();
    exp_q.delete();
    model_capture(8, 12'h300, 12'h040, lane_a);
    load(8, 12'h300, 12'h040, lane_a);
    tick();
    bus.serial_we = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (observe() !== e) begin
        n_err++;
        $display("FAIL rmid_write%0d got=%h exp=%h", i, observe(), e);
      end
      if (i == 1) load(2, 12'h010, 12'h010, lane_b);
      if (i == 2) xrst = 1'b0;
      tick();
      bus.serial_we = 1'b0;
    end
    n_cmp++;
    if ({observe(), overrun} !== 32'h0) begin
      n_err++;
      $display("FAIL rmid_reset got=%h exp=0", {observe(), overrun});
    end
    prev_addr = '0;
    prev_data = '0;
    exp_q.delete();
    model_capture(3, 12'hABC, 12'h222, lane_b);
    xrst = 1'b1;
    load(3, 12'hABC, 12'h222, lane_b);
    tick();
    bus.serial_we = 1'b0;
    while (exp_q.size() > 0) begin
      cyc_t e;
      e = exp_q.pop_front();
      n_cmp++;
      if (observe() !== e) begin
        n_err++;
        $display("FAIL rmid_after got=%h exp=%h", observe(), e);
      end
      prev_addr = e.addr;
      prev_data = e.data;
      tick();
    end
    n_cmp++;
    if ({observe(), overrun} !== {idle_exp(), 1'b0}) begin
      n_err++;
      $display("FAIL rmid_idle got=%h exp=%h", {observe(), overrun}, {idle_exp(), 1'b0});
    end
  endtask

  initial begin
    bus.serial_we = 1'b0;
    bus.in_data   = '0;
    bus.base_addr = '0;
    bus.stride    = '0;
    bus.n_lanes   = '0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/renkon_serial.md
RENKON_SERIAL -- requirements
Module: renkon_serial

Interface
- REQ-001: Parameter DWIDTH, default 16, signed feature word width.
- REQ-002: Parameter CORE, default 8, number of parallel pool lanes.
- REQ-003: Parameter CORELOG, default 3, log2(CORE).
- REQ-004: Parameter OUTSIZE, default 12, output feature memory address width.
- REQ-005: clk  input  1  single clock; all state updates on its rising edge.
- REQ-006: xrst  input  1  reset, synchronous, active-low.
- REQ-007: serial_we  input  1  capture strobe; one-cycle pulse when the pool stage presents valid lane outputs.
- REQ-008: in_data  input  CORE*DWIDTH  packed signed pool outputs; lane k occupies bits [k*DWIDTH +: DWIDTH].
- REQ-009: base_addr  input  OUTSIZE  write address of lane 0, sampled at capture.
- REQ-010: stride  input  OUTSIZE  address increment between consecutive lanes (one output channel plane), sampled at capture.
- REQ-011: n_lanes  input  CORELOG+1  number of valid lanes, sampled at capture.
- REQ-012: overrun_clr  input  1  clears the overrun flag.
- REQ-013: mem_we  output  1  feature memory write enable.
- REQ-014: mem_addr  output  OUTSIZE  feature memory write address.
- REQ-015: mem_data  output  DWIDTH  signed feature memory write data.
- REQ-016: busy  output  1  high while draining.
- REQ-017: done  output  1  one-cycle pulse coincident with the last write of a drain.
- REQ-018: overrun  output  1  sticky error: capture strobe lost.

Function
- REQ-019: FSM states IDLE and DRAIN; all outputs SHALL be registered.
- REQ-020: Accepted capture: IDLE with serial_we=1 and n_lanes!=0 latches all lanes, base_addr, stride, and clamped count, enters DRAIN next cycle.
- REQ-021: n_lanes > CORE SHALL be clamped to CORE; n_lanes=0 SHALL make the strobe a no-op: no capture, no writes, no overrun.
- REQ-022: In DRAIN, one write per cycle: mem_we=1, mem_data=lane[idx], mem_addr=base+idx*stride, idx counting 0..count-1.
- REQ-023: Address SHALL be formed by accumulation (no multiplier) and wrap modulo 2^OUTSIZE.
- REQ-024: First write SHALL appear in the cycle after the accepted strobe (latency 1).
- REQ-025: busy=1 in every DRAIN cycle, 0 in IDLE.
- REQ-026: done=1 only in the cycle of write idx=count-1.
- REQ-027: Zero-bubble chaining: serial_we on the last-write cycle with n_lanes!=0 is accepted; next cycle writes lane 0 of the new capture, FSM stays in DRAIN.
- REQ-028: serial_we in DRAIN on a non-last cycle SHALL be ignored (captured data unchanged) and set overrun.
- REQ-029: overrun stays 1 until overrun_clr=1 or reset; a simultaneous set and clear leaves overrun=1.
- REQ-030: In IDLE, mem_we=0 and mem_addr/mem_data SHALL hold their last values.

Reset
- REQ-031: xrst=0 at a clock edge SHALL force IDLE, idx=0, mem_we=0, mem_addr=0, mem_data=0, busy=0, done=0, overrun=0, and clear captured lanes.
- REQ-032: Reset mid-drain SHALL abort with no further writes; the first cycle after release is IDLE and honours serial_we.
- REQ-033: serial_we asserted during reset SHALL be ignored.

Verification
- REQ-034: Strobe, n_lanes=8, base=0x010, stride=0x040, lanes 1..8 -> 8 consecutive writes addr 0x010,0x050,...,0x1D0, data 1..8, done on 8th, busy 8 cycles.
- REQ-035: n_lanes=3, base=0xFC0, stride=0x020, lanes -5,7,-1 -> addr 0xFC0,0xFE0,0x000 (wrap), data -5,7,-1, done on 3rd.
- REQ-036: Second strobe on last-write cycle of a 4-lane drain -> 4+4 writes with no idle cycle, two done pulses, overrun=0.
- REQ-037: Strobe on 2nd cycle of an 8-lane drain -> original 8 writes unchanged, overrun=1 until overrun_clr pulse.
- REQ-038: n_lanes=0 strobe -> no writes, busy=0, overrun=0; n_lanes=15 -> 8 writes.
- REQ-039: xrst=0 on 3rd write of 8-lane drain -> mem_we=0, busy=0 from next cycle, all outputs at reset values; new strobe after release drains normally.
